// File: rtl/psum_sched_pkg.sv
// Shared constants and types for the PSUM accumulation sequencer.
//   - Geometry: input map IN_W x IN_W, kernel K_W x K_W, output OUT_W x OUT_W.
//   - Typed "last index" constants keep the top-level comparisons width-exact.
//   - state_t: FSM encoding shared by the top level.
package psum_sched_pkg;

    localparam int IN_W     = 6;
    localparam int K_W      = 3;
    localparam int OUT_W    = IN_W - K_W + 1;
    localparam int LEN_NIJ  = IN_W * IN_W;
    localparam int LEN_ONIJ = OUT_W * OUT_W;

    localparam int ADDR_BW  = 4;
    localparam int NIJ_BW   = $clog2(LEN_NIJ);
    localparam int KIJ_BW   = 4;

    localparam logic [KIJ_BW-1:0]  KIJ_MAX   = KIJ_BW'(K_W * K_W - 1);
    localparam logic [NIJ_BW-1:0]  NIJ_LAST  = NIJ_BW'(LEN_NIJ - 1);
    localparam logic [ADDR_BW-1:0] ONIJ_LAST = ADDR_BW'(LEN_ONIJ - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCUM   = 3'd1,
        DRAIN   = 3'd2,
        READOUT = 3'd3,
        RDRAIN  = 3'd4
    } state_t;

endpackage

// File: rtl/psum_addr_map.sv
// Combinational input-pixel to output-pixel mapper.
// For input pixel nij under kernel offset kij, reports whether the pixel lands
// inside the output window and, if so, which output pixel it accumulates into.
//   nij  in   NIJ_BW   input pixel index (row-major)
//   kij  in   KIJ_BW   kernel index (row-major), must be a legal index
//   hit  out  1        pixel contributes to an output pixel
//   onij out  ADDR_BW  output pixel index (row-major), 0 on a miss
module psum_addr_map
    import psum_sched_pkg::*;
(
    input  logic [NIJ_BW-1:0]  nij,
    input  logic [KIJ_BW-1:0]  kij,
    output logic               hit,
    output logic [ADDR_BW-1:0] onij
);

    // Signed intermediates so that rows/columns left of the window go negative.
    int orow;
    int ocol;

    always_comb begin
        orow = int'(nij) / IN_W - int'(kij) / K_W;
        ocol = int'(nij) % IN_W - int'(kij) % K_W;
        hit  = (orow >= 0) && (orow < OUT_W) && (ocol >= 0) && (ocol < OUT_W);
        onij = hit ? ADDR_BW'(orow * OUT_W + ocol) : '0;
    end

endmodule

// File: rtl/psum_acc_sched.sv
// Sequencer for the SFU / PSUM-SRAM accumulation path.
// An accumulation pass pops one OFIFO psum vector per input pixel, maps it to
// its output pixel for the latched kernel index and issues a read-modify-write
// to the PSUM SRAM. A readout pass streams all 16 PSUM entries to the SFU bus.
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   start          in   pulse: begin an accumulation pass for kij
//   kij            in   kernel index, sampled when start is accepted
//   ofifo_valid    in   OFIFO holds a psum vector
//   ofifo_rd       out  OFIFO pop (combinational)
//   ren_pmem       out  PSUM read enable, r_A_pmem read address
//   wen_pmem       out  PSUM write enable, w_A_pmem write address
//   add_en         out  SFU accumulate (1) or overwrite (0), aligned with wen
//   readout_start  in   pulse: begin 16-entry readout
//   readout_valid  out  SFU readout bus holds entry readout_idx
//   busy           out  a pass is in progress
//   pass_done      out  pulse with the final write / final readout beat
//   kij_err        out  sticky: start seen with an illegal kij
module psum_acc_sched
    import psum_sched_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [KIJ_BW-1:0]  kij,
    input  logic               ofifo_valid,
    output logic               ofifo_rd,
    output logic               ren_pmem,
    output logic [ADDR_BW-1:0] r_A_pmem,
    output logic               wen_pmem,
    output logic [ADDR_BW-1:0] w_A_pmem,
    output logic               add_en,
    input  logic               readout_start,
    output logic               readout_valid,
    output logic [ADDR_BW-1:0] readout_idx,
    output logic               busy,
    output logic               pass_done,
    output logic               kij_err
);

    state_t              state, state_next;
    logic [NIJ_BW-1:0]   nij_cnt;
    logic [ADDR_BW-1:0]  ro_cnt;
    logic                drain_cnt;
    logic [KIJ_BW-1:0]   kij_q;

    logic                map_hit;
    logic [ADDR_BW-1:0]  map_onij;

    // Stage 1 of the write pipeline (read stage), plus readout tag.
    logic                s1_valid;
    logic [ADDR_BW-1:0]  s1_addr;
    logic                ro_s1;

    logic pop, start_ok, start_bad, ro_go, ro_issue, acc_rd, in_drain;

    psum_addr_map u_addr_map (
        .nij  (nij_cnt),
        .kij  (kij_q),
        .hit  (map_hit),
        .onij (map_onij)
    );

    assign pop       = (state == ACCUM) && ofifo_valid;
    assign start_ok  = (state == IDLE) && start && (kij <= KIJ_MAX);
    assign start_bad = (state == IDLE) && start && (kij > KIJ_MAX);
    // start has priority over readout_start in the same idle cycle.
    assign ro_go     = (state == IDLE) && readout_start && !start;
    assign ro_issue  = ro_go || (state == READOUT);
    // The first kernel index overwrites, so no read of the old value is needed.
    assign acc_rd    = pop && map_hit && (kij_q != '0);
    assign in_drain  = (state == DRAIN) || (state == RDRAIN);

    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start_ok)   state_next = ACCUM;
                else if (ro_go) state_next = READOUT;
            end
            ACCUM:   if (pop && (nij_cnt == NIJ_LAST)) state_next = DRAIN;
            DRAIN:   if (drain_cnt)                    state_next = IDLE;
            READOUT: if (ro_cnt == ONIJ_LAST)          state_next = RDRAIN;
            RDRAIN:  if (drain_cnt)                    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ofifo_rd  = pop;
        busy      = (state != IDLE);
        // Second drain cycle carries the last write / last readout beat.
        pass_done = in_drain && drain_cnt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nij_cnt       <= '0;
            ro_cnt        <= '0;
            drain_cnt     <= 1'b0;
            kij_q         <= '0;
            kij_err       <= 1'b0;
            s1_valid      <= 1'b0;
            s1_addr       <= '0;
            ro_s1         <= 1'b0;
            ren_pmem      <= 1'b0;
            r_A_pmem      <= '0;
            wen_pmem      <= 1'b0;
            w_A_pmem      <= '0;
            add_en        <= 1'b0;
            readout_valid <= 1'b0;
            readout_idx   <= '0;
        end else begin
            if (start_ok) begin
                kij_q   <= kij;
                nij_cnt <= '0;
                kij_err <= 1'b0;
            end else if (start_bad) begin
                kij_err <= 1'b1;
            end

            if (pop) nij_cnt <= (nij_cnt == NIJ_LAST) ? '0 : nij_cnt + NIJ_BW'(1);
            // Wraps back to 0 after the 16th read, ready for the next readout.
            if (ro_issue) ro_cnt <= ro_cnt + ADDR_BW'(1);

            drain_cnt <= in_drain && !drain_cnt;

            // Read stage: accumulation read or readout read (never both).
            s1_valid <= pop && map_hit;
            s1_addr  <= (pop && map_hit) ? map_onij : '0;
            ro_s1    <= ro_issue;
            ren_pmem <= acc_rd || ro_issue;
            r_A_pmem <= ro_issue ? ro_cnt : (acc_rd ? map_onij : '0);

            // Write stage, one cycle behind the read stage.
            wen_pmem <= s1_valid;
            w_A_pmem <= s1_valid ? s1_addr : '0;
            add_en   <= s1_valid && (kij_q != '0);

            // SRAM read data appears one cycle after the read address.
            readout_valid <= ro_s1;
            readout_idx   <= ro_s1 ? r_A_pmem : '0;
        end
    end

endmodule

// File: tb/tb_psum_acc_sched.sv
module tb_psum_acc_sched;

    logic       clk = 1'b0;
    logic       reset, start, ofifo_valid, readout_start;
    logic [3:0] kij;
    logic       ofifo_rd, ren_pmem, wen_pmem, add_en, readout_valid, busy, pass_done, kij_err;
    logic [3:0] r_A_pmem, w_A_pmem, readout_idx;

    always #5 clk = ~clk;

    psum_acc_sched dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .kij           (kij),
        .ofifo_valid   (ofifo_valid),
        .ofifo_rd      (ofifo_rd),
        .ren_pmem      (ren_pmem),
        .r_A_pmem      (r_A_pmem),
        .wen_pmem      (wen_pmem),
        .w_A_pmem      (w_A_pmem),
        .add_en        (add_en),
        .readout_start (readout_start),
        .readout_valid (readout_valid),
        .readout_idx   (readout_idx),
        .busy          (busy),
        .pass_done     (pass_done),
        .kij_err       (kij_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Per-pass event log, indexed by event number; cycle 0 is the start cycle.
    int pop_cyc  [64];
    int ren_cyc  [64];
    int ren_addr [64];
    int wen_cyc  [64];
    int wen_addr [64];
    int wen_add  [64];
    int ro_cyc   [32];
    int ro_idx   [32];
    int n_pop, n_ren, n_wen, n_ro, n_done, done_cyc;
    int gap_pops, bad_rd, err_c1, err_last, busy_after, hit_reset;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        for (int i = 0; i < 64; i++) begin
            pop_cyc[i] = -1; ren_cyc[i] = -1; ren_addr[i] = -1;
            wen_cyc[i] = -1; wen_addr[i] = -1; wen_add[i] = -1;
        end
        for (int i = 0; i < 32; i++) begin
            ro_cyc[i] = -1; ro_idx[i] = -1;
        end
        n_pop = 0; n_ren = 0; n_wen = 0; n_ro = 0; n_done = 0; done_cyc = -1;
        gap_pops = 0; bad_rd = 0; err_c1 = -1; err_last = -1; busy_after = -1; hit_reset = 0;
    endtask

    task automatic sample(input int c);
        if (ofifo_rd) begin
            if (n_pop < 64) pop_cyc[n_pop] = c;
            n_pop++;
            if (!ofifo_valid) bad_rd++;
        end
        if (ren_pmem) begin
            if (n_ren < 64) begin ren_cyc[n_ren] = c; ren_addr[n_ren] = int'(r_A_pmem); end
            n_ren++;
        end
        if (wen_pmem) begin
            if (n_wen < 64) begin
                wen_cyc[n_wen] = c; wen_addr[n_wen] = int'(w_A_pmem); wen_add[n_wen] = int'(add_en);
            end
            n_wen++;
        end
        if (readout_valid) begin
            if (n_ro < 32) begin ro_cyc[n_ro] = c; ro_idx[n_ro] = int'(readout_idx); end
            n_ro++;
        end
        if (pass_done) begin
            n_done++;
            done_cyc = c;
        end
    endtask

    // Inputs change 1 ns after the rising edge, outputs are sampled 1 ns later.
    task automatic run_pass(input logic [3:0] k, input int gap_at, input int gap_len,
                            input logic also_ro, input int busy_start_at);
        int  gap_left;
        logic in_gap;
        clear_log();
        gap_left = gap_len;
        @(posedge clk); #1;
        start = 1'b1; kij = k; readout_start = also_ro; ofifo_valid = 1'b1;
        #1 sample(0);
        for (int c = 1; c < 200; c++) begin
            @(posedge clk); #1;
            start = 1'b0; readout_start = 1'b0; kij = k;
            if (c == busy_start_at) begin start = 1'b1; kij = 4'd9; end
            in_gap = (gap_at >= 0) && (n_pop == gap_at) && (gap_left > 0);
            ofifo_valid = !in_gap;
            if (in_gap) gap_left--;
            #1 sample(c);
            if (in_gap && ofifo_rd) gap_pops++;
            if (c == 1) err_c1 = int'(kij_err);
            if (n_done > 0 && c >= done_cyc + 2) break;
        end
        start = 1'b0; ofifo_valid = 1'b0;
        err_last = int'(kij_err);
        busy_after = int'(busy);
    endtask

    // Every kij gives write addresses 0..15 in order; hit i comes from
    // input pixel (i/4 + kij/3)*6 + i%4 + kij%3.
    task automatic check_pass(input string nm, input int k);
        int nij_i;
        check({nm, " pops"}, n_pop, 36);
        check({nm, " wen count"}, n_wen, 16);
        check({nm, " ren count"}, n_ren, (k == 0) ? 0 : 16);
        check({nm, " pass_done count"}, n_done, 1);
        check({nm, " pass_done cycle"}, done_cyc, pop_cyc[35] + 2);
        check({nm, " busy after"}, busy_after, 0);
        for (int i = 0; i < 16; i++) begin
            nij_i = (i / 4 + k / 3) * 6 + (i % 4) + (k % 3);
            check($sformatf("%s wen%0d addr", nm, i), wen_addr[i], i);
            check($sformatf("%s wen%0d cyc", nm, i), wen_cyc[i], pop_cyc[nij_i] + 2);
            check($sformatf("%s wen%0d add_en", nm, i), wen_add[i], (k != 0) ? 1 : 0);
            if (k != 0) begin
                check($sformatf("%s ren%0d addr", nm, i), ren_addr[i], i);
                check($sformatf("%s ren%0d cyc", nm, i), ren_cyc[i], pop_cyc[nij_i] + 1);
            end
        end
    endtask

    task automatic run_readout(input int reset_idx);
        clear_log();
        @(posedge clk); #1;
        start = 1'b0; readout_start = 1'b1;
        #1 sample(0);
        for (int c = 1; c < 40; c++) begin
            @(posedge clk); #1;
            readout_start = 1'b0;
            #1 sample(c);
            if (reset_idx >= 0 && readout_valid && int'(readout_idx) == reset_idx) begin
                reset = 1'b0;
                #1 hit_reset = 1;
                break;
            end
            if (n_done > 0 && c >= done_cyc + 2) break;
        end
    endtask

    task automatic check_zero(input string nm);
        check({nm, " ofifo_rd"}, ofifo_rd, 0);
        check({nm, " ren_pmem"}, ren_pmem, 0);
        check({nm, " r_A_pmem"}, r_A_pmem, 0);
        check({nm, " wen_pmem"}, wen_pmem, 0);
        check({nm, " w_A_pmem"}, w_A_pmem, 0);
        check({nm, " add_en"}, add_en, 0);
        check({nm, " readout_valid"}, readout_valid, 0);
        check({nm, " readout_idx"}, readout_idx, 0);
        check({nm, " busy"}, busy, 0);
        check({nm, " pass_done"}, pass_done, 0);
        check({nm, " kij_err"}, kij_err, 0);
    endtask

    initial begin
        // Reset with OFIFO claiming data: nothing may pop.
        reset = 1'b0; start = 1'b0; kij = 4'd0; ofifo_valid = 1'b1; readout_start = 1'b0;
        repeat (3) @(posedge clk);
        #2 check_zero("reset");
        @(posedge clk); #1 reset = 1'b1;
        ofifo_valid = 1'b0;

        // Illegal kij: error flag, no pass.
        @(posedge clk); #1 start = 1'b1; kij = 4'd9;
        @(posedge clk); #1 start = 1'b0; kij = 4'd0;
        #1 check("kij9 kij_err", kij_err, 1);
        check("kij9 busy", busy, 0);
        @(posedge clk); #2 check("kij9 sticky", kij_err, 1);
        check("kij9 still idle", busy, 0);

        // kij=0, readout_start in the same cycle: accumulation must win.
        run_pass(4'd0, -1, 0, 1'b1, -1);
        check_pass("k0", 0);
        check("k0 kij_err cleared", err_c1, 0);
        check("k0 no readout", n_ro, 0);

        // kij=4: first hit nij 7 -> onij 0, last hit nij 28 -> onij 15.
        run_pass(4'd4, -1, 0, 1'b0, -1);
        check_pass("k4", 4);
        check("k4 nij0 miss: first ren after nij7 pop", ren_cyc[0], pop_cyc[7] + 1);
        check("k4 nij28 -> onij15 write", wen_cyc[15], pop_cyc[28] + 2);

        // kij=8 with an illegal start while busy, which must be ignored.
        run_pass(4'd8, -1, 0, 1'b0, 5);
        check_pass("k8", 8);
        check("k8 nij14 -> onij0 read", ren_cyc[0], pop_cyc[14] + 1);
        check("k8 busy start ignored", err_last, 0);

        // kij=2 with a 5-cycle OFIFO gap after 10 pops.
        run_pass(4'd2, 10, 5, 1'b0, -1);
        check_pass("k2gap", 2);
        check("k2gap pops in gap", gap_pops, 0);
        check("k2gap pop w/o valid", bad_rd, 0);
        check("k2gap pop after gap", pop_cyc[10], pop_cyc[9] + 6);

        // Full readout: ren cycles 1..16, valid cycles 2..17, done with last beat.
        run_readout(-1);
        check("ro valid count", n_ro, 16);
        check("ro ren count", n_ren, 16);
        check("ro no writes", n_wen, 0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ro ren%0d addr", i), ren_addr[i], i);
            check($sformatf("ro ren%0d cyc", i), ren_cyc[i], i + 1);
            check($sformatf("ro beat%0d idx", i), ro_idx[i], i);
            check($sformatf("ro beat%0d cyc", i), ro_cyc[i], i + 2);
        end
        check("ro pass_done count", n_done, 1);
        check("ro pass_done cycle", done_cyc, 17);

        // Readout interrupted by reset at idx 7: outputs clear immediately.
        run_readout(7);
        check("ro reset reached idx7", hit_reset, 1);
        check_zero("mid-readout reset");
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #2 check("post-reset busy", busy, 0);
        check("post-reset readout_valid", readout_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
